// File: rtl/cdb_broadcast_pkg.sv
// Shared types and constants for the CDB completion path: packet/tag layouts,
// FU index constants and the round-robin pick helper.
package cdb_broadcast_pkg;

   localparam int NUM_FU     = 4;
   localparam int DEPTH      = 2;
   localparam int PHYS_REG_W = 6;
   localparam int RS_IDX_W   = 4;
   localparam int FU_W       = $clog2(NUM_FU);
   localparam int CNT_W      = $clog2(DEPTH + 1);

   localparam int FU_ALU   = 0;
   localparam int FU_MULT  = 1;
   localparam int FU_LOAD  = 2;
   localparam int FU_STORE = 3;

   typedef struct packed {
      logic [PHYS_REG_W-1:0] phys_reg;
      logic [RS_IDX_W-1:0]   rs_idx;
      logic                  has_dest;
      logic [31:0]           value;
   } CDB_PACKET;

   typedef struct packed {
      logic [PHYS_REG_W-1:0] phys_reg;
      logic                  valid;
      logic                  ready;
   } TAG;

   typedef struct packed {
      logic                remove_en;
      logic [RS_IDX_W-1:0] remove_idx;
   } EX_RS_PACKET;

   // Returns {found, index}: first set candidate scanning upward from start, wrapping.
   function automatic logic [FU_W:0] rr_pick(input logic [NUM_FU-1:0] cand,
                                             input logic [FU_W-1:0]   start);
      logic            found;
      logic [FU_W-1:0] idx;
      logic [FU_W-1:0] sel;
      found = 1'b0;
      idx   = start;
      sel   = start;
      for (int k = 0; k < NUM_FU; k++) begin
         if (!found && cand[idx]) begin
            found = 1'b1;
            sel   = idx;
         end else begin
            found = found;
         end
         idx = (idx == FU_W'(NUM_FU - 1)) ? {FU_W{1'b0}} : idx + FU_W'(1);
      end
      return {found, sel};
   endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-FU circular completion queue with head/tail pointers, occupancy count
// and a synchronous flush that dominates push and pop.
module cdb_fifo
   import cdb_broadcast_pkg::*;
#(
   parameter int ENTRIES = 2
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           push,
   input  CDB_PACKET                      push_pkt,
   input  logic                           pop,
   output CDB_PACKET                      head,
   output logic [$clog2(ENTRIES+1)-1:0]   count,
   output logic                           full
);

   localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int CW    = $clog2(ENTRIES + 1);

   CDB_PACKET        mem_r [ENTRIES];
   logic [PTR_W-1:0] head_ptr_r;
   logic [PTR_W-1:0] tail_ptr_r;
   logic [CW-1:0]    count_r;
   logic             push_s;
   logic             pop_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(ENTRIES - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   assign push_s = push && !full;
   assign pop_s  = pop && (count_r != {CW{1'b0}});
   assign full   = (count_r == CW'(ENTRIES));
   assign count  = count_r;
   assign head   = mem_r[head_ptr_r];

   // Queue storage, pointers and occupancy.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_ptr_r <= {PTR_W{1'b0}};
         tail_ptr_r <= {PTR_W{1'b0}};
         count_r    <= {CW{1'b0}};
         for (int i = 0; i < ENTRIES; i++) begin
            mem_r[i] <= {$bits(CDB_PACKET){1'b0}};
         end
      end else if (flush) begin
         head_ptr_r <= {PTR_W{1'b0}};
         tail_ptr_r <= {PTR_W{1'b0}};
         count_r    <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            mem_r[tail_ptr_r] <= push_pkt;
            tail_ptr_r        <= ptr_inc(tail_ptr_r);
         end
         if (pop_s) begin
            head_ptr_r <= ptr_inc(head_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/cdb_broadcast.sv
// CDB completion stage: per-FU queues, round-robin grant of one CDB slot per
// cycle, registered tag/value broadcast and RS free. Define CDB_BYPASS_EN to let
// an empty queue's incoming completion win arbitration directly (1-cycle latency).
module cdb_broadcast
   import cdb_broadcast_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              interrupt,
   input  logic [NUM_FU-1:0] fu_done,
   input  CDB_PACKET         fu_pkt [NUM_FU],
   output logic [NUM_FU-1:0] fu_stall,
   output TAG                cdb,
   output logic              cdb_en,
   output logic [31:0]       cdb_value,
   output EX_RS_PACKET       ex_rs_packet
);

   CDB_PACKET         head_s [NUM_FU];
   logic [CNT_W-1:0]  count_s [NUM_FU];
   logic [NUM_FU-1:0] full_s;
   logic [NUM_FU-1:0] empty_s;
   logic [NUM_FU-1:0] cand_s;
   logic [NUM_FU-1:0] push_s;
   logic [NUM_FU-1:0] pop_s;
   logic [FU_W:0]     pick_s;
   logic              grant_s;
   logic [FU_W-1:0]   grant_idx_s;
   logic              bypass_s;
   CDB_PACKET         grant_pkt_s;
   logic [FU_W-1:0]   rr_ptr_r;

   for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
      cdb_fifo #(.ENTRIES(DEPTH)) u_fifo (
         .clock    (clock),
         .reset    (reset),
         .flush    (interrupt),
         .push     (push_s[g]),
         .push_pkt (fu_pkt[g]),
         .pop      (pop_s[g]),
         .head     (head_s[g]),
         .count    (count_s[g]),
         .full     (full_s[g])
      );
   end

   // Stall depends only on registered occupancy, never on this cycle's pop.
   assign fu_stall = full_s;

   // Candidate selection, round-robin grant and per-queue push/pop strobes.
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         empty_s[i] = (count_s[i] == {CNT_W{1'b0}});
      end
`ifdef CDB_BYPASS_EN
      cand_s = ~empty_s | fu_done;
`else
      cand_s = ~empty_s;
`endif
      pick_s      = rr_pick(cand_s, rr_ptr_r);
      grant_s     = pick_s[FU_W];
      grant_idx_s = pick_s[FU_W-1:0];
`ifdef CDB_BYPASS_EN
      bypass_s    = grant_s && empty_s[grant_idx_s];
      grant_pkt_s = bypass_s ? fu_pkt[grant_idx_s] : head_s[grant_idx_s];
`else
      bypass_s    = 1'b0;
      grant_pkt_s = head_s[grant_idx_s];
`endif
      for (int i = 0; i < NUM_FU; i++) begin
         push_s[i] = fu_done[i] && !full_s[i] && !interrupt &&
                     !(bypass_s && (grant_idx_s == FU_W'(i)));
         pop_s[i]  = grant_s && (grant_idx_s == FU_W'(i)) && !empty_s[i] && !interrupt;
      end
   end

   // Broadcast/free output registers and round-robin pointer.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cdb          <= {$bits(TAG){1'b0}};
         cdb_en       <= 1'b0;
         cdb_value    <= 32'h0000_0000;
         ex_rs_packet <= {$bits(EX_RS_PACKET){1'b0}};
         rr_ptr_r     <= {FU_W{1'b0}};
      end else if (interrupt) begin
         cdb_en                 <= 1'b0;
         ex_rs_packet.remove_en <= 1'b0;
         rr_ptr_r               <= {FU_W{1'b0}};
      end else if (grant_s) begin
         cdb.phys_reg            <= grant_pkt_s.phys_reg;
         cdb.valid               <= grant_pkt_s.has_dest;
         cdb.ready               <= grant_pkt_s.has_dest;
         cdb_en                  <= grant_pkt_s.has_dest;
         cdb_value               <= grant_pkt_s.value;
         ex_rs_packet.remove_en  <= 1'b1;
         ex_rs_packet.remove_idx <= grant_pkt_s.rs_idx;
         rr_ptr_r <= (grant_idx_s == FU_W'(NUM_FU - 1)) ? {FU_W{1'b0}}
                                                        : grant_idx_s + FU_W'(1);
      end else begin
         cdb_en                 <= 1'b0;
         ex_rs_packet.remove_en <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cdb_broadcast.sv
// Directed self-checking bench for cdb_broadcast; the CDB_BYPASS_EN build runs
// the bypass latency vector instead of the queued-path vectors.
module tb_cdb_broadcast;
   import cdb_broadcast_pkg::*;

   logic              clock = 1'b0;
   logic              reset;
   logic              interrupt;
   logic [NUM_FU-1:0] fu_done;
   CDB_PACKET         fu_pkt [NUM_FU];
   logic [NUM_FU-1:0] fu_stall;
   TAG                cdb;
   logic              cdb_en;
   logic [31:0]       cdb_value;
   EX_RS_PACKET       ex_rs_packet;

   int vectors     = 0;
   int miscompares = 0;

   cdb_broadcast dut (
      .clock        (clock),
      .reset        (reset),
      .interrupt    (interrupt),
      .fu_done      (fu_done),
      .fu_pkt       (fu_pkt),
      .fu_stall     (fu_stall),
      .cdb          (cdb),
      .cdb_en       (cdb_en),
      .cdb_value    (cdb_value),
      .ex_rs_packet (ex_rs_packet)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_grant(input string tag, input int phys, input int rs, input logic [31:0] val);
      chk({tag, "_en"},   {63'd0, cdb_en}, 64'd1);
      chk({tag, "_tag"},  {58'd0, cdb.phys_reg}, 64'(phys));
      chk({tag, "_vr"},   {62'd0, cdb.valid, cdb.ready}, 64'd3);
      chk({tag, "_rem"},  {59'd0, ex_rs_packet}, {59'd0, 1'b1, 4'(rs)});
      chk({tag, "_val"},  {32'd0, cdb_value}, {32'd0, val});
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_en"},  {63'd0, cdb_en}, 64'd0);
      chk({tag, "_rem"}, {63'd0, ex_rs_packet.remove_en}, 64'd0);
   endtask

   function automatic CDB_PACKET mk(input int phys, input int rs, input logic hd, input logic [31:0] v);
      CDB_PACKET p;
      p.phys_reg = PHYS_REG_W'(phys);
      p.rs_idx   = RS_IDX_W'(rs);
      p.has_dest = hd;
      p.value    = v;
      return p;
   endfunction

   initial begin
      reset     = 1'b0;
      interrupt = 1'b0;
      fu_done   = 4'b0000;
      for (int i = 0; i < NUM_FU; i++) fu_pkt[i] = mk(0, 0, 1'b0, 32'd0);
      tick();
      tick();
      chk("rst_en",    {63'd0, cdb_en}, 64'd0);
      chk("rst_tag",   {56'd0, cdb}, 64'd0);
      chk("rst_val",   {32'd0, cdb_value}, 64'd0);
      chk("rst_rs",    {59'd0, ex_rs_packet}, 64'd0);
      chk("rst_stall", {60'd0, fu_stall}, 64'd0);
      reset = 1'b1;
      tick();

`ifdef CDB_BYPASS_EN
      // Idle block, LOAD completes: visible after a single edge.
      fu_pkt[FU_LOAD] = mk(40, 5, 1'b1, 32'h0000_1234);
      fu_done = 4'b0100;
      tick();
      fu_done = 4'b0000;
      chk_grant("byp", 40, 5, 32'h0000_1234);
      tick();
      chk_idle("byp_after");
`else
      // All four FUs complete at one edge with rr_ptr=0: drained in order 0..3.
      for (int i = 0; i < NUM_FU; i++) fu_pkt[i] = mk(20 + i, 4 + i, 1'b1, 32'(100 + i));
      fu_done = 4'b1111;
      tick();
      fu_done = 4'b0000;
      chk_idle("all_e1");
      for (int i = 0; i < NUM_FU; i++) begin
         tick();
         chk_grant($sformatf("all_fu%0d", i), 20 + i, 4 + i, 32'(100 + i));
      end
      tick();
      chk_idle("all_drained");

      // MULT pushes three back-to-back behind ALU traffic; third is held by stall.
      fu_pkt[FU_ALU]  = mk(30, 1, 1'b1, 32'h0000_0A00);
      fu_pkt[FU_MULT] = mk(40, 8, 1'b1, 32'h0000_0B00);
      fu_done = 4'b0011;
      tick();
      chk_idle("mul_e1");
      chk("mul_e1_stall", {60'd0, fu_stall}, 64'd0);
      fu_pkt[FU_ALU]  = mk(31, 2, 1'b1, 32'h0000_0A01);
      fu_pkt[FU_MULT] = mk(41, 9, 1'b1, 32'h0000_0B01);
      tick();
      chk_grant("mul_a0", 30, 1, 32'h0000_0A00);
      chk("mul_stall_full", {60'd0, fu_stall}, 64'h2);
      fu_done = 4'b0010;
      fu_pkt[FU_MULT] = mk(42, 10, 1'b1, 32'h0000_0B02);
      tick();
      chk_grant("mul_m0", 40, 8, 32'h0000_0B00);
      chk("mul_stall_free", {60'd0, fu_stall}, 64'd0);
      tick();
      fu_done = 4'b0000;
      chk_grant("mul_a1", 31, 2, 32'h0000_0A01);
      chk("mul_stall_again", {60'd0, fu_stall}, 64'h2);
      tick();
      chk_grant("mul_m1", 41, 9, 32'h0000_0B01);
      tick();
      chk_grant("mul_m2", 42, 10, 32'h0000_0B02);
      tick();
      chk_idle("mul_done");

      // Single ALU completion: 2-edge latency, one-cycle pulse, tag holds after.
      fu_pkt[FU_ALU] = mk(12, 3, 1'b1, 32'hA5A5_0001);
      fu_done = 4'b0001;
      tick();
      fu_done = 4'b0000;
      chk_idle("alu_e1");
      tick();
      chk_grant("alu", 12, 3, 32'hA5A5_0001);
      tick();
      chk_idle("alu_after");
      chk("alu_hold_tag", {58'd0, cdb.phys_reg}, 64'd12);
      chk("alu_hold_val", {32'd0, cdb_value}, 64'hA5A5_0001);

      // Store: frees the RS entry without a broadcast.
      fu_pkt[FU_STORE] = mk(7, 2, 1'b0, 32'd55);
      fu_done = 4'b1000;
      tick();
      fu_done = 4'b0000;
      tick();
      chk("st_en",  {63'd0, cdb_en}, 64'd0);
      chk("st_rem", {59'd0, ex_rs_packet}, {59'd0, 1'b1, 4'd2});
      tick();
      chk_idle("st_after");

      // Two queued entries flushed by interrupt; the same-cycle MULT push is dropped.
      fu_pkt[FU_ALU]  = mk(50, 11, 1'b1, 32'd1);
      fu_pkt[FU_LOAD] = mk(51, 12, 1'b1, 32'd2);
      fu_done = 4'b0101;
      tick();
      fu_pkt[FU_MULT] = mk(52, 13, 1'b1, 32'd3);
      fu_done   = 4'b0010;
      interrupt = 1'b1;
      tick();
      interrupt = 1'b0;
      fu_done   = 4'b0000;
      chk_idle("irq_e");
      chk("irq_stall", {60'd0, fu_stall}, 64'd0);
      tick();
      chk_idle("irq_e1");
      tick();
      chk_idle("irq_e2");

      // Asynchronous reset mid-stream clears outputs between clock edges.
      fu_pkt[FU_ALU] = mk(33, 6, 1'b1, 32'hDEAD_BEEF);
      fu_done = 4'b0001;
      tick();
      fu_done = 4'b0000;
      tick();
      chk_grant("pre_arst", 33, 6, 32'hDEAD_BEEF);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_en",  {63'd0, cdb_en}, 64'd0);
      chk("arst_tag", {56'd0, cdb}, 64'd0);
      chk("arst_val", {32'd0, cdb_value}, 64'd0);
      chk("arst_rs",  {59'd0, ex_rs_packet}, 64'd0);
      tick();
      reset = 1'b1;
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
